// File: rtl/conv_stream_engine_if.sv
// Pixel-memory read port and output pixel stream of the convolution engine.
// The engine uses the master modport; the image memory and stream sink use slave.
interface conv_stream_engine_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10,
    parameter int NUM_CH = 8,
    parameter int ACC_W  = 24,
    parameter int X_W    = 5,
    parameter int Y_W    = 5
);
    logic                    pix_rd;
    logic [ADDR_W-1:0]       pix_addr;
    logic [DATA_W-1:0]       pix_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [NUM_CH*ACC_W-1:0] out_data;
    logic [X_W-1:0]          out_x;
    logic [Y_W-1:0]          out_y;
    logic                    out_last;

    modport master (
        output pix_rd, pix_addr, out_valid, out_data, out_x, out_y, out_last,
        input  pix_data, out_ready
    );

    modport slave (
        input  pix_rd, pix_addr, out_valid, out_data, out_x, out_y, out_last,
        output pix_data, out_ready
    );
endinterface

// File: rtl/conv_stream_engine.sv
// Time-multiplexed KxK valid-padding convolution: one pixel read per cycle,
// NUM_CH parallel MACs, one output pixel (all channels) per stream handshake.
module conv_stream_engine #(
    parameter int DATA_W   = 8,
    parameter int WEIGHT_W = 8,
    parameter int IMG_W    = 28,
    parameter int IMG_H    = 28,
    parameter int K        = 5,
    parameter int NUM_CH   = 8,
    parameter int ACC_W    = 24,
    parameter int ADDR_W   = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       relu_en,
    output logic                       busy,
    output logic                       done,
    input  logic                       w_we,
    input  logic [$clog2(NUM_CH)-1:0]  w_ch,
    input  logic [$clog2(K*K)-1:0]     w_addr,
    input  logic signed [WEIGHT_W-1:0] w_data,
    conv_stream_engine_if.master       bus
);
    localparam int TAPS  = K * K;
    localparam int TAP_W = $clog2(TAPS);
    localparam int KI_W  = $clog2(K);
    localparam int X_W   = $clog2(IMG_W);
    localparam int Y_W   = $clog2(IMG_H);
    localparam int OW    = IMG_W - K + 1;
    localparam int OH    = IMG_H - K + 1;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_LAST, S_OUT} state_e;

    state_e                     state_q, state_d;
    logic [TAP_W-1:0]           tap_q, tap_d;
    logic [KI_W-1:0]            kr_q, kr_d, kc_q, kc_d;
    logic                       mac_en_q, mac_en_d;
    logic [TAP_W-1:0]           mac_tap_q, mac_tap_d;
    logic [X_W-1:0]             x_q, x_d;
    logic [Y_W-1:0]             y_q, y_d;
    logic                       relu_q, relu_d;
    logic                       done_q, done_d;
    logic signed [ACC_W-1:0]    acc_q [NUM_CH];
    logic signed [ACC_W-1:0]    acc_d [NUM_CH];
    logic signed [WEIGHT_W-1:0] weight_q [NUM_CH][TAPS];
    logic signed [WEIGHT_W-1:0] weight_d [NUM_CH][TAPS];

    logic                    pix_rd_c;
    logic                    at_end;
    logic [NUM_CH*ACC_W-1:0] out_data_c;

    assign at_end = (x_q == X_W'(OW - 1)) && (y_q == Y_W'(OH - 1));

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its _d input, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            tap_q     <= '0;
            kr_q      <= '0;
            kc_q      <= '0;
            mac_en_q  <= 1'b0;
            mac_tap_q <= '0;
            x_q       <= '0;
            y_q       <= '0;
            relu_q    <= 1'b0;
            done_q    <= 1'b0;
            // NOTE: weights are a flop array, not a RAM, precisely so that reset
            // can clear every entry in a single cycle.
            for (int c = 0; c < NUM_CH; c++) begin
                acc_q[c] <= '0;
                for (int n = 0; n < TAPS; n++) weight_q[c][n] <= '0;
            end
        end else begin
            state_q   <= state_d;
            tap_q     <= tap_d;
            kr_q      <= kr_d;
            kc_q      <= kc_d;
            mac_en_q  <= mac_en_d;
            mac_tap_q <= mac_tap_d;
            x_q       <= x_d;
            y_q       <= y_d;
            relu_q    <= relu_d;
            done_q    <= done_d;
            acc_q     <= acc_d;
            weight_q  <= weight_d;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned, which would otherwise infer a latch.
        state_d   = state_q;
        tap_d     = tap_q;
        kr_d      = kr_q;
        kc_d      = kc_q;
        x_d       = x_q;
        y_d       = y_q;
        relu_d    = relu_q;
        done_d    = 1'b0;
        acc_d     = acc_q;
        weight_d  = weight_q;
        pix_rd_c  = 1'b0;

        // Pixel data arrives one cycle after its read, so the MAC uses the tap
        // index registered alongside that read.
        if (mac_en_q) begin
            for (int c = 0; c < NUM_CH; c++) begin
                acc_d[c] = acc_q[c]
                         + ACC_W'($signed({1'b0, bus.pix_data})) * ACC_W'(weight_q[c][mac_tap_q]);
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (w_we && (32'(w_ch) < NUM_CH) && (32'(w_addr) < TAPS))
                    weight_d[w_ch][w_addr] = w_data;
                if (start) begin
                    relu_d  = relu_en;
                    x_d     = '0;
                    y_d     = '0;
                    tap_d   = '0;
                    kr_d    = '0;
                    kc_d    = '0;
                    for (int c = 0; c < NUM_CH; c++) acc_d[c] = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                pix_rd_c = 1'b1;
                tap_d    = tap_q + 1'b1;
                if (kc_q == KI_W'(K - 1)) begin
                    kc_d = '0;
                    kr_d = kr_q + 1'b1;
                end else begin
                    kc_d = kc_q + 1'b1;
                end
                if (tap_q == TAP_W'(TAPS - 1)) state_d = S_LAST;
            end
            S_LAST: state_d = S_OUT;
            S_OUT: begin
                if (bus.out_ready) begin
                    if (at_end) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        if (x_q == X_W'(OW - 1)) begin
                            x_d = '0;
                            y_d = y_q + 1'b1;
                        end else begin
                            x_d = x_q + 1'b1;
                        end
                        tap_d   = '0;
                        kr_d    = '0;
                        kc_d    = '0;
                        for (int c = 0; c < NUM_CH; c++) acc_d[c] = '0;
                        state_d = S_FETCH;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        mac_en_d  = pix_rd_c;
        mac_tap_d = tap_q;
    end

    always_comb begin
        out_data_c = '0;
        for (int c = 0; c < NUM_CH; c++)
            out_data_c[c*ACC_W +: ACC_W] = (relu_q && acc_q[c][ACC_W-1]) ? '0 : acc_q[c];
    end

    assign busy          = (state_q != S_IDLE);
    assign done          = done_q;
    assign bus.pix_rd    = pix_rd_c;
    assign bus.pix_addr  = pix_rd_c ? ((ADDR_W'(y_q) + ADDR_W'(kr_q)) * ADDR_W'(IMG_W)
                                       + ADDR_W'(x_q) + ADDR_W'(kc_q)) : '0;
    assign bus.out_valid = (state_q == S_OUT);
    assign bus.out_data  = out_data_c;
    assign bus.out_x     = x_q;
    assign bus.out_y     = y_q;
    assign bus.out_last  = (state_q == S_OUT) && at_end;
endmodule

// File: tb/tb_conv_stream_engine.sv
// Scoreboard bench for conv_stream_engine: a loop-based convolution model fills
// the expected queue at start; a negedge monitor pops and compares on handshakes.
module tb_conv_stream_engine;
    localparam int DATA_W = 8, WEIGHT_W = 8, IMG_W = 28, IMG_H = 28, K = 5;
    localparam int NUM_CH = 8, ACC_W = 24, ADDR_W = 10;
    localparam int TAPS = K * K, OW = IMG_W - K + 1, OH = IMG_H - K + 1;
    localparam int NOUT = OW * OH, OUT_W = NUM_CH * ACC_W;
    localparam int CH_W = $clog2(NUM_CH), TAP_W = $clog2(TAPS);
    localparam int X_W = $clog2(IMG_W), Y_W = $clog2(IMG_H);

    logic clk = 1'b0;
    logic rst = 1'b1, start = 1'b0, relu_en = 1'b0, w_we = 1'b0;
    logic [CH_W-1:0] w_ch = '0;
    logic [TAP_W-1:0] w_addr = '0;
    logic signed [WEIGHT_W-1:0] w_data = '0;
    logic busy, done;

    conv_stream_engine_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_CH(NUM_CH),
                            .ACC_W(ACC_W), .X_W(X_W), .Y_W(Y_W)) bus ();

    conv_stream_engine #(.DATA_W(DATA_W), .WEIGHT_W(WEIGHT_W), .IMG_W(IMG_W), .IMG_H(IMG_H),
                         .K(K), .NUM_CH(NUM_CH), .ACC_W(ACC_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .start(start), .relu_en(relu_en), .busy(busy), .done(done),
        .w_we(w_we), .w_ch(w_ch), .w_addr(w_addr), .w_data(w_data), .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [OUT_W-1:0] data;
        int               x;
        int               y;
        bit               last;
    } exp_t;

    exp_t sb[$];
    int   img [2**ADDR_W];
    int   wgt [NUM_CH][TAPS];
    int   n_checks = 0, n_fail = 0, n_out = 0, cyc = 0, last_hs_cyc = 0;
    bit   rand_ready = 1'b0, bp_armed = 1'b0;

    task automatic check(input string name, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Image memory: data returned one cycle after the read strobe.
    always @(posedge clk) if (bus.pix_rd) bus.pix_data <= DATA_W'(img[bus.pix_addr]);

    // Stream sink: ready is high, random, or held low 10 cycles at output 5.
    initial begin
        int  hold;
        bit  fired;
        hold = 0;
        fired = 1'b0;
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (!bp_armed) fired = 1'b0;
            if (bp_armed && !fired && bus.out_valid && n_out == 5) begin
                fired = 1'b1;
                hold  = 10;
            end
            if (hold > 0) begin
                bus.out_ready = 1'b0;
                hold--;
            end else begin
                bus.out_ready = rand_ready ? ($urandom_range(3) != 0) : 1'b1;
            end
        end
    end

    // Monitor: compare on handshake, check hold-stability and no reads while in OUT.
    initial begin
        logic [OUT_W-1:0] snap_data;
        int   snap_x, snap_y;
        bit   snap_last, stalled;
        exp_t e;
        stalled = 1'b0;
        forever begin
            @(negedge clk);
            if (rst || !bus.out_valid) begin
                stalled = 1'b0;
            end else begin
                check("no_read_in_out", OUT_W'(bus.pix_rd), '0);
                if (stalled) begin
                    check("stall_data_stable", bus.out_data, snap_data);
                    check("stall_xy_stable", OUT_W'({bus.out_x, bus.out_y, bus.out_last}),
                          OUT_W'({X_W'(snap_x), Y_W'(snap_y), snap_last}));
                end
                if (bus.out_ready) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_output: got x=%0d y=%0d expected none",
                                 bus.out_x, bus.out_y);
                    end else begin
                        e = sb.pop_front();
                        check("out_data", bus.out_data, e.data);
                        check("out_xy_last", OUT_W'({bus.out_x, bus.out_y, bus.out_last}),
                              OUT_W'({X_W'(e.x), Y_W'(e.y), e.last}));
                    end
                    n_out++;
                    last_hs_cyc = cyc;
                    stalled = 1'b0;
                end else begin
                    stalled   = 1'b1;
                    snap_data = bus.out_data;
                    snap_x    = int'(bus.out_x);
                    snap_y    = int'(bus.out_y);
                    snap_last = bus.out_last;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Reference: direct valid-padding convolution over the image and weight arrays.
    task automatic push_expected(input bit relu);
        exp_t e;
        int   s;
        for (int y = 0; y < OH; y++) begin
            for (int x = 0; x < OW; x++) begin
                e.data = '0;
                for (int c = 0; c < NUM_CH; c++) begin
                    s = 0;
                    for (int i = 0; i < K; i++)
                        for (int j = 0; j < K; j++)
                            s += img[(y + i) * IMG_W + x + j] * wgt[c][i * K + j];
                    if (relu && s < 0) s = 0;
                    e.data[c*ACC_W +: ACC_W] = s[ACC_W-1:0];
                end
                e.x = x;
                e.y = y;
                e.last = (x == OW - 1) && (y == OH - 1);
                sb.push_back(e);
            end
        end
    endtask

    task automatic load_weights();
        for (int c = 0; c < NUM_CH; c++) begin
            for (int n = 0; n < TAPS; n++) begin
                w_we = 1'b1;
                w_ch = CH_W'(c);
                w_addr = TAP_W'(n);
                w_data = WEIGHT_W'(wgt[c][n]);
                tick();
            end
        end
        w_we = 1'b0;
    endtask

    task automatic set_weights(input int v);
        for (int c = 0; c < NUM_CH; c++)
            for (int n = 0; n < TAPS; n++) wgt[c][n] = v;
    endtask

    task automatic start_run(input bit relu, output int busy_cyc);
        push_expected(relu);
        relu_en = relu;
        start = 1'b1;
        tick();
        start = 1'b0;
        relu_en = 1'b0;
        busy_cyc = cyc;
        check("busy_after_start", OUT_W'(busy), OUT_W'(1));
    endtask

    task automatic wait_outputs(input int cnt, input int budget);
        int target;
        target = n_out + cnt;
        for (int i = 0; i < budget && n_out < target; i++) tick();
        if (n_out < target) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_outputs_timeout: got %0d outputs expected %0d", n_out, target);
        end
    endtask

    // Reset clears the DUT weights; the model follows suit.
    task automatic abort_run();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        set_weights(0);
    endtask

    task automatic run_to_done(input int budget, output int first_valid, output int done_c);
        first_valid = -1;
        done_c = -1;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (bus.out_valid && first_valid < 0) first_valid = cyc;
            if (done) begin
                done_c = cyc;
                check("busy_low_with_done", OUT_W'(busy), '0);
                break;
            end
        end
        if (done_c < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: got no done expected done within %0d cycles", budget);
        end
    endtask

    initial begin
        int b0, fv, dc, base;
        bit relu;

        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0, fv, dc, base;
        bit relu;

        for (int i = 0; i < 2**ADDR_W; i++) img[i] = 0;
        set_weights(0);
        repeat (3) tick();
        check("rst_busy", OUT_W'(busy), '0);
        check("rst_done", OUT_W'(done), '0);
        check("rst_pix_rd", OUT_W'(bus.pix_rd), '0);
        check("rst_pix_addr", OUT_W'(bus.pix_addr), '0);
        check("rst_out_valid_last", OUT_W'({bus.out_valid, bus.out_last}), '0);
        check("rst_out_data", bus.out_data, '0);
        check("rst_out_xy", OUT_W'({bus.out_x, bus.out_y}), '0);
        rst = 1'b0;
        tick();

        // Identity/sign with a 10-cycle stall at output 5 and ignored controls mid-run.
        for (int r = 0; r < IMG_H; r++)
            for (int c = 0; c < IMG_W; c++) img[r * IMG_W + c] = (r + c) % 256;
        wgt[0][TAPS / 2] = 1;
        wgt[1][TAPS / 2] = -1;
        load_weights();
        bp_armed = 1'b1;
        start_run(1'b0, b0);
        wait_outputs(50, 5000);
        start = 1'b1;
        relu_en = 1'b1;
        w_we = 1'b1;
        w_ch = '0;
        w_addr = TAP_W'(TAPS / 2);
        w_data = 8'sd77;
        tick();
        start = 1'b0;
        relu_en = 1'b0;
        w_we = 1'b0;
        check("busy_kept_after_ignored_start", OUT_W'(busy), OUT_W'(1));
        run_to_done(20000, fv, dc);
        check("identity_all_consumed", OUT_W'(sb.size()), '0);
        bp_armed = 1'b0;

        // Same weights retained in IDLE; ReLU clamps ch1.
        start_run(1'b1, b0);
        wait_outputs(15, 2000);
        abort_run();

        // Full image: all ones, saturated pixels, ready held high.
        for (int i = 0; i < IMG_W * IMG_H; i++) img[i] = 255;
        set_weights(1);
        load_weights();
        base = n_out;
        start_run(1'b0, b0);
        run_to_done(NOUT * 27 + 100, fv, dc);
        check("first_valid_latency", OUT_W'(fv - b0), OUT_W'(TAPS + 1));
        check("start_to_done_cycles", OUT_W'(dc - b0), OUT_W'(NOUT * 27));
        check("done_after_last_hs", OUT_W'(dc - last_hs_cyc), OUT_W'(1));
        check("full_output_count", OUT_W'(n_out - base), OUT_W'(NOUT));
        check("full_all_consumed", OUT_W'(sb.size()), '0);
        tick();
        check("done_one_cycle", OUT_W'(done), '0);

        // Negative extreme without and with ReLU.
        for (int pass = 0; pass < 2; pass++) begin
            set_weights(-128);
            load_weights();
            start_run(pass[0], b0);
            wait_outputs(8, 1000);
            abort_run();
        end

        // Random data, weights, ReLU and backpressure; out-of-range taps must be ignored.
        for (int i = 0; i < IMG_W * IMG_H; i++) img[i] = int'($urandom_range(255));
        for (int c = 0; c < NUM_CH; c++)
            for (int n = 0; n < TAPS; n++) wgt[c][n] = int'($urandom_range(255)) - 128;
        load_weights();
        for (int a = TAPS; a < 2**TAP_W; a++) begin
            w_we = 1'b1;
            w_ch = CH_W'($urandom_range(NUM_CH - 1));
            w_addr = TAP_W'(a);
            w_data = WEIGHT_W'($urandom_range(255));
            tick();
        end
        w_we = 1'b0;
        rand_ready = 1'b1;
        relu = 1'($urandom_range(1));
        start_run(relu, b0);
        wait_outputs(40, 3000);
        rand_ready = 1'b0;
        start_run_guard: begin end
        wait_outputs(10, 1000);
        abort_run();

        // Reset during FETCH of output 100, then a fresh run sees cleared weights.
        set_weights(3);
        load_weights();
        start_run(1'b0, b0);
        wait_outputs(100, 4000);
        repeat (3) tick();
        check("in_fetch_before_reset", OUT_W'({busy, bus.pix_rd}), OUT_W'(2'b11));
        rst = 1'b1;
        tick();
        check("reset_busy_low", OUT_W'(busy), '0);
        check("reset_out_valid_low", OUT_W'(bus.out_valid), '0);
        rst = 1'b0;
        sb.delete();
        set_weights(0);
        start_run(1'b0, b0);
        wait_outputs(10, 1000);
        abort_run();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/conv_stream_engine.md
Name: conv_stream_engine

Overview:
- Time-multiplexed K×K valid-padding convolution engine; the sequential successor to the fully parallel conv layer.
- Reads one pixel per cycle from an external image memory and applies NUM_CH filters in parallel, with one MAC per channel.
- Emits one output pixel (all channels) per handshake on a valid/ready stream, in row-major order.
- Optional ReLU; weights are loaded through a write port into internal registers.

Parameters:
- DATA_W, 8, unsigned pixel width
- WEIGHT_W, 8, signed weight width
- IMG_W, 28, image width (columns)
- IMG_H, 28, image height (rows)
- K, 5, kernel size (K×K)
- NUM_CH, 8, number of filters/output channels
- ACC_W, 24, signed accumulator/output width; must be ≥ DATA_W+WEIGHT_W+clog2(K*K)+1
- ADDR_W, 10, pixel address width; must satisfy 2^ADDR_W ≥ IMG_W*IMG_H

Ports:
- clk, input, 1, clock
- rst, input, 1, synchronous active-high reset
- start, input, 1, begin a full-image convolution (honoured only in IDLE)
- relu_en, input, 1, sampled with start; 1 = clamp negative outputs to 0
- busy, output, 1, high from the cycle after an accepted start until done
- done, output, 1, one-cycle pulse after the final output handshake
- w_we, input, 1, weight write enable (ignored while busy)
- w_ch, input, clog2(NUM_CH), weight channel select
- w_addr, input, clog2(K*K), tap index i*K+j (i = row, j = column)
- w_data, input, WEIGHT_W, signed weight value
- pix_rd, output, 1, pixel read strobe
- pix_addr, output, ADDR_W, pixel address, computed as row*IMG_W+col
- pix_data, input, DATA_W, pixel value, valid exactly one cycle after pix_rd
- out_valid, output, 1, output stream valid
- out_ready, input, 1, output stream ready
- out_data, output, NUM_CH*ACC_W, channel c at bits [c*ACC_W +: ACC_W]
- out_x, output, clog2(IMG_W), output column
- out_y, output, clog2(IMG_H), output row
- out_last, output, 1, high with the final output pixel

Behaviour:
- Output map size: OW = IMG_W-K+1, OH = IMG_H-K+1. Outputs are produced y-outer, x-inner.
- Reset:
  - busy, done, pix_rd, out_valid, out_last = 0.
  - pix_addr, out_data, out_x, out_y = 0.
  - FSM → IDLE.
  - All weight registers cleared to 0.
  - Reset mid-operation aborts immediately; no further output.
- FSM states: IDLE, FETCH, LAST, OUT.
- IDLE:
  - w_we writes weight[w_ch][w_addr] <= w_data.
  - start=1 latches relu_en, sets x=y=0, clears accumulators, goes to FETCH.
- FETCH, for n = 0..K*K-1 (K*K cycles):
  - pix_rd=1, pix_addr=(y+n/K)*IMG_W+(x+n%K).
  - In the cycle after read n: acc[c] += zext(pix_data)*sext(weight[c][n]) for every c.
- LAST (1 cycle): pix_rd=0; performs the final MAC (tap K*K-1).
- OUT:
  - out_valid=1.
  - out_data[c] = (relu && acc[c]<0) ? 0 : acc[c].
  - out_x=x, out_y=y, out_last=(x==OW-1 && y==OH-1).
  - All out_* signals are held stable until out_valid && out_ready.
  - On handshake: if out_last, go to IDLE; done=1 for one cycle, busy=0 the same cycle.
  - Otherwise advance x (wrap to 0 and increment y at OW-1), clear accumulators, go to FETCH.
  - No pixel reads occur while stalled in OUT.
- Latency with out_ready held high: K*K+2 cycles per output, so the first out_valid appears K*K+2 cycles after the start cycle.
- Arithmetic:
  - Signed two's complement in ACC_W bits.
  - Overflow wraps and is not saturated; it cannot occur when the ACC_W constraint holds.
- Ignored inputs:
  - start while busy is ignored.
  - w_we while busy is ignored; weights are unchanged.
  - Out-of-range w_ch/w_addr writes are ignored.

Test Plan:
- Identity and sign:
  - Stimulus: pixel[r][c]=(r+c)%256; ch0 centre tap=+1, ch1 centre tap=-1, all other taps 0; relu=0.
  - Response: every output has ch0=pixel[y+2][x+2] and ch1=-ch0; with relu=1, ch1=0.
- Full image:
  - Stimulus: all weights +1, all pixels 255, out_ready=1.
  - Response: 576 outputs, each channel 6375; out_last only at (23,23); done pulses one cycle after the final handshake; total 576*27 cycles from start to done.
- Negative extreme:
  - Stimulus: all weights -128, pixels 255.
  - Response: every output -816000 (0xF38C80 in 24 bits); with relu=1, 0.
- Backpressure:
  - Stimulus: drop out_ready for 10 cycles at output 5.
  - Response: out_* stable throughout, pix_rd=0 throughout, the next output carries the correct coordinates, and no output is lost or duplicated.
- Reset mid-run:
  - Stimulus: assert rst during FETCH of output 100.
  - Response: next cycle busy=0 and out_valid=0; weights are 0, so a new start yields all-zero outputs.
- Ignored controls:
  - Stimulus: start pulse and w_we while busy.
  - Response: no restart, weights unchanged, and the output sequence is identical to an undisturbed run.
